pkt_uart_tx: RTL

Downstream stage of the camera packet sequencer. Merges ROM template bytes with the sequencer's substituted field bytes (row number, frame markers, checksum) into one byte stream. Buffers the stream in an on-chip FIFO and serialises it on a UART line, 8N1, LSB first. Returns the 2-bit back-pressure vector that the sequencer samples as rx_full.

---
 rtl/pkt_uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/pkt_uart_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pkt_uart_pkg.sv
// Shared constants and TX state encoding for the packet UART transmitter.
package pkt_uart_pkg;

    localparam logic [15:0] CLK_DIV_DEF = 16'd434;
    localparam int unsigned FIFO_AW_DEF = 13;
    localparam logic [12:0] PKT_MAX_DEF = 13'd4142;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStart = 3'd2,
        StData  = 3'd3,
        StStop  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO on an inferred block RAM; registered read, no fall-through.
module sync_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    localparam int unsigned Depth = 1 << AW;

    logic [DW-1:0] mem [Depth];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_wr, do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_rd) begin
            rd_data <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

    assign level = level_q;
    assign empty = (level_q == '0);
    assign full  = (level_q == (AW + 1)'(Depth));

endmodule

// File: rtl/pkt_uart_tx.sv
// Merges template/substitute bytes into a FIFO and serialises them as 8N1 UART, LSB first.
module pkt_uart_tx
    import pkt_uart_pkg::*;
#(
    parameter logic [15:0] CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned FIFO_AW = FIFO_AW_DEF,
    parameter logic [12:0] PKT_MAX = PKT_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  rom_dout,
    input  logic [7:0]  in_change,
    input  logic        in_flag,
    output logic [1:0]  rx_full,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic [31:0] byte_cnt
);

    localparam logic [FIFO_AW:0] DepthW = (FIFO_AW + 1)'(1 << FIFO_AW);

    logic [7:0]       wr_data, rd_data;
    logic             wr_en, rd_en, empty, full;
    logic [FIFO_AW:0] level, level_next, free_next;

    tx_state_e   state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [31:0] cnt_q, cnt_d;
    logic        txd_q, txd_d;
    logic        busy_q, low_q, ovf_q;
    logic        bit_done;

    assign wr_data = in_flag ? in_change : rom_dout;
    assign wr_en   = in_valid & ~full;

    sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .level   (level)
    );

    // Space check looks at the level after this edge, including a concurrent read.
    assign level_next = level + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, rd_en};
    assign free_next  = DepthW - level_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            low_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (!in_valid) low_q <= (free_next < (FIFO_AW + 1)'(PKT_MAX));
            if (in_valid && full) ovf_q <= 1'b1;
        end
    end

    assign bit_done = (timer_q == 16'd0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    rd_en   = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shift_d = rd_data;
                timer_d = CLK_DIV - 16'd1;
                state_d = StStart;
            end
            StStart: begin
                if (bit_done) begin
                    timer_d = CLK_DIV - 16'd1;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            StData: begin
                if (bit_done) begin
                    timer_d = CLK_DIV - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    cnt_d = cnt_q + 32'd1;
                    if (!empty) begin
                        rd_en   = 1'b1;
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the state being entered so the output flop changes with it.
        case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            busy_q  <= (state_q != StIdle) | ~empty;
        end
    end

    assign rx_full  = {low_q, ovf_q};
    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;
    assign byte_cnt = cnt_q;

endmodule
